// File: rtl/logic_stream_reducer.sv
// rtl/logic_stream_reducer.sv - frame-wide bitwise AND/OR/XOR/NOT/PASS reducer with valid/ready streams
// One registered result per frame; the op is latched on the first beat of each frame.
module logic_stream_reducer #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_overflow;

    logic               w_accept;
    logic               w_xfer;
    logic [2:0]         w_op;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_hit_max;
    logic               w_close;
    logic               w_ovf;
    logic               w_invert;
    logic [WIDTH-1:0]   w_result;

    assign w_accept   = in_valid & in_ready;
    assign w_xfer     = out_valid & out_ready;
    assign w_op       = (r_state == S_IDLE) ? op : r_op;
    assign w_cnt_next = (r_state == S_IDLE) ? ONE_CNT : r_count + ONE_CNT;
    assign w_hit_max  = (w_cnt_next == MAX_CNT);
    assign w_close    = w_accept & (in_last | w_hit_max);
    assign w_ovf      = ~in_last & w_hit_max;

    // Inverting ops accumulate in their plain form; the inversion is applied once at close.
    always_comb begin
        w_acc_next = in_data;
        if (r_state != S_IDLE) begin
            case (r_op)
                3'd0, 3'd3: w_acc_next = r_acc & in_data;
                3'd1, 3'd4: w_acc_next = r_acc | in_data;
                3'd2, 3'd5: w_acc_next = r_acc ^ in_data;
                default:    w_acc_next = in_data;
            endcase
        end
    end

    always_comb begin
        w_invert = 1'b0;
        case (w_op)
            3'd3, 3'd4, 3'd5, 3'd6: w_invert = 1'b1;
            default:                w_invert = 1'b0;
        endcase
    end

    assign w_result = w_invert ? ~w_acc_next : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b1;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_close ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_close) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (w_xfer) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= '0;
            r_count        <= '0;
            r_op           <= 3'd0;
            r_out_data     <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc   <= w_acc_next;
                r_count <= w_cnt_next;
                if (r_state == S_IDLE) begin
                    r_op <= op;
                end
            end
            if (w_close) begin
                r_out_data     <= w_result;
                r_out_count    <= w_cnt_next;
                r_out_overflow <= w_ovf;
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;

endmodule

// File: doc/logic_stream_reducer.md
Name: logic_stream_reducer

Overview:
- Parametrised successor to the team's single-gate primitives (AND/OR/NOT cells).
- Applies a selectable bitwise logic operation across a stream of WIDTH-bit beats and produces one registered result per frame.
- Valid/ready handshake on both sides.
- Sits between test-pattern sources and checkers in the logic-primitive library, and is reusable wherever a frame-wide AND/OR/XOR reduction is needed.

Parameters:
- WIDTH, 8: data width of each beat and of the result; WIDTH >= 1.
- MAX_BEATS, 16: maximum beats per frame; MAX_BEATS >= 1. Reaching it closes the frame.
- CNT_W, $clog2(MAX_BEATS+1): width of out_count. Derived; do not override.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  beat payload.
- in_last  in  1  final beat of frame.
- op  in  3  operation code; sampled only on the first beat of a frame.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  frame result.
- out_count  out  CNT_W  number of beats in the frame.
- out_overflow  out  1  frame force-closed at MAX_BEATS without in_last.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, accumulator=0, count=0, stored op=0.
  - out_valid=0, out_data=0, out_count=0, out_overflow=0.
  - in_ready=1 once reset is released.
  - Any partial frame is discarded; no output is produced for it.
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 NOT: result = ~(last accepted beat).
  - 7 PASS: result = last accepted beat.
  - NAND/NOR/XNOR accumulate as AND/OR/XOR; the inversion is applied once when the result is registered, not per beat.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - in_ready = (state != HOLD), driven combinationally from state only.
  - Output transfer occurs on out_valid & out_ready.
- FSM:
  - IDLE, on accept:
    - store op; acc = in_data; count = 1.
    - if in_last or MAX_BEATS==1 -> HOLD; else -> ACCUM.
  - ACCUM, on accept:
    - acc = acc <op> in_data; count = count+1.
    - if in_last -> HOLD.
    - else if count+1 == MAX_BEATS -> HOLD with overflow=1.
    - no accept -> stay.
  - HOLD:
    - out_valid=1; out_data/out_count/out_overflow registered and stable until transfer.
    - on transfer -> IDLE, out_valid=0 next cycle.
    - out_data keeps its last value after transfer; it is don't-care while out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the closing beat, i.e. it is visible the cycle after that beat. Throughput is one bubble per frame, since in_ready=0 in HOLD.
- Boundaries:
  - op changes mid-frame are ignored.
  - Single-beat frame with in_last: count=1.
  - MAX_BEATS=1 with in_last=0: overflow=1.
  - Beats offered during HOLD are not accepted and must be held by the source.
  - A beat following an overflow close starts a new frame, even if it carries in_last.
  - out_ready held high in HOLD gives a 1-cycle pulse of out_valid.
  - Reset asserted during HOLD drops the pending result.

Test Plan (WIDTH=8, MAX_BEATS=4):
1. OR frame: op=1, beats 0x0F, 0xA0(last), out_ready=1 -> out_valid high one cycle after last accept; out_data=0xAF, out_count=2, out_overflow=0; in_ready back to 1 the cycle after transfer.
2. NAND with op change: op=3 on beat 0xFF, then op=1 on 0xF0 and 0x3C(last) -> out_data=0xCF (~0x30), out_count=3. The later op is ignored.
3. Single-beat XOR then NOT/PASS: op=2, 0x5A(last) -> 0x5A, count 1. Then op=6, beats 0x11, 0x01(last) -> 0xFE. Then op=7, 0x33(last) -> 0x33.
4. Overflow: op=0, beats 0xFF, 0x7F, 0x3F, 0x1F, none with last -> 0x1F, count=4, overflow=1. Next beat 0x80(last) with op=1 is a new frame -> 0x80, count=1, overflow=0.
5. Backpressure: after a 0xAF result, hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_data=0xAF and count stay stable; in_ready=0; no beat consumed. Then out_ready=1 -> transfer, IDLE, the pending beat is accepted next cycle.
6. Reset mid-frame: OR beats 0x01, 0x02 accepted, then rst_n=0 asynchronously (mid-cycle) -> out_valid=0, out_data=0 immediately. Release rst_n, then op=4, beat 0x0F(last) -> out_data=0xF0, count=1; no residue from the aborted frame.
